// File: rtl/lsu_pkg.sv
// Shared types and helpers for the load/store unit memory controller.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StCapture,
        StResp
    } lsu_state_e;

    function automatic logic [7:0] size_mask(input logic [1:0] size);
        case (size)
            SZ_B:    return 8'h01;
            SZ_H:    return 8'h03;
            SZ_W:    return 8'h0f;
            default: return 8'hff;
        endcase
    endfunction

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] offset);
        case (size)
            SZ_H:    return offset[0];
            SZ_W:    return |offset[1:0];
            SZ_D:    return |offset;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: store mask and data replication, load shift and extension.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [2:0]  offset,
    input  logic        sign_ext,
    input  logic [63:0] wdata,
    input  logic [63:0] rdata,
    output logic [7:0]  we_mask,
    output logic [63:0] wdata_rep,
    output logic [63:0] rdata_ext
);

    logic [63:0] shifted;

    assign we_mask = size_mask(size) << offset;
    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        wdata_rep = wdata;
        rdata_ext = shifted;
        case (size)
            SZ_B: begin
                wdata_rep = {8{wdata[7:0]}};
                rdata_ext = {{56{sign_ext & shifted[7]}}, shifted[7:0]};
            end
            SZ_H: begin
                wdata_rep = {4{wdata[15:0]}};
                rdata_ext = {{48{sign_ext & shifted[15]}}, shifted[15:0]};
            end
            SZ_W: begin
                wdata_rep = {2{wdata[31:0]}};
                rdata_ext = {{32{sign_ext & shifted[31]}}, shifted[31:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Single-outstanding load/store controller in front of a one-cycle-latency SRAM.
module lsu_mem_ctrl
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64  // lane logic assumes exactly 8 byte lanes
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_en,
    output logic [7:0]        mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        state_q;
    logic              we_q;
    logic [1:0]        size_q;
    logic [2:0]        off_q;
    logic              signed_q;
    logic              resp_valid_q;
    logic              resp_err_q;
    logic [DATA_W-1:0] resp_rdata_q;
    logic              mem_en_q;
    logic [7:0]        mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic [1:0]        lane_size;
    logic [2:0]        lane_off;
    logic [7:0]        lane_we;
    logic [DATA_W-1:0] lane_wdata;
    logic [DATA_W-1:0] lane_rdata;

    // Store steering is needed at the accept edge, load extraction in CAPTURE.
    assign lane_size = (state_q == StIdle) ? req_size : size_q;
    assign lane_off  = (state_q == StIdle) ? req_addr[2:0] : off_q;

    lsu_lane_align u_lane_align (
        .size      (lane_size),
        .offset    (lane_off),
        .sign_ext  (signed_q),
        .wdata     (req_wdata),
        .rdata     (mem_rdata),
        .we_mask   (lane_we),
        .wdata_rep (lane_wdata),
        .rdata_ext (lane_rdata)
    );

    assign req_ready  = (state_q == StIdle) && !rst;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_en     = mem_en_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            we_q         <= 1'b0;
            size_q       <= SZ_B;
            off_q        <= 3'd0;
            signed_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 8'h00;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q     <= req_we;
                        size_q   <= req_size;
                        off_q    <= req_addr[2:0];
                        signed_q <= req_signed;
                        if (misaligned(req_size, req_addr[2:0])) begin
                            state_q      <= StResp;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            state_q     <= StAccess;
                            mem_en_q    <= 1'b1;
                            mem_addr_q  <= {req_addr[ADDR_W-1:3], 3'b000};
                            mem_we_q    <= req_we ? lane_we : 8'h00;
                            mem_wdata_q <= req_we ? lane_wdata : '0;
                        end
                    end
                end
                StAccess: begin
                    mem_en_q    <= 1'b0;
                    mem_we_q    <= 8'h00;
                    mem_addr_q  <= '0;
                    mem_wdata_q <= '0;
                    if (we_q) begin
                        state_q      <= StResp;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end else begin
                        state_q <= StCapture;
                    end
                end
                StCapture: begin
                    state_q      <= StResp;
                    resp_valid_q <= 1'b1;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= lane_rdata;
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q      <= StIdle;
                        resp_valid_q <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
